// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus round-robin arbiter.
// Holds the FSM state enum, the master-index width helper and default timeout.
package mem_bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_TIMEOUT = 255;
  localparam int TMO_W       = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_rr_picker.sv
// Combinational round-robin priority encoder: searches last+1, last+2, ...
// Ports: req_i requests, last_i previous winner; gnt_o one-hot, idx_o, valid_o.
module rr_picker
  import mem_bus_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int c;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_i) + k) % N;
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_bus_rr_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_MASTERS masters.
// Ports: clk, reset (async, high); m_* per-master request/response buses
// (flattened, master i at slice i); address/read/write/mask/value bus outputs;
// read_value_in/ready_in/fault_in from the bus; grant_out one-hot debug grant.
// Optional bus watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_rr_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MASTERS*32-1:0]   m_address_in,
  input  logic [NUM_MASTERS-1:0]      m_read_in,
  input  logic [NUM_MASTERS-1:0]      m_write_in,
  input  logic [NUM_MASTERS*4-1:0]    m_write_mask_in,
  input  logic [NUM_MASTERS*32-1:0]   m_write_value_in,
  output logic [NUM_MASTERS*32-1:0]   m_read_value_out,
  output logic [NUM_MASTERS-1:0]      m_ready_out,
  output logic [NUM_MASTERS-1:0]      m_fault_out,
  output logic [31:0]                 address_out,
  output logic                        read_out,
  output logic                        write_out,
  output logic [3:0]                  write_mask_out,
  output logic [31:0]                 write_value_out,
  input  logic [31:0]                 read_value_in,
  input  logic                        ready_in,
  input  logic                        fault_in,
  output logic [NUM_MASTERS-1:0]      grant_out
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = idx_w(N);

  if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("mem_bus_rr_arbiter: parameter out of range");
  end

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  last_q, last_d;

  logic [N-1:0]   req;
  logic [N-1:0]   pk_gnt;
  logic [IW-1:0]  pk_idx;
  logic           pk_valid;
  logic           busy, g_req, expire;
  logic           done, tmo, abort;

  assign req   = m_read_in | m_write_in;
  assign busy  = (state_q == BUSY);
  assign g_req = req[idx_q];

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pk_gnt),
    .idx_o   (pk_idx),
    .valid_o (pk_valid)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // cnt_q counts BUSY cycles already elapsed; expiry is the TIMEOUT-th
  assign expire = busy && (cnt_q == TMO_W'(TIMEOUT - 1));
  assign cnt_d  = busy ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // a dropped request wins over expiry: nobody is left to take the fault
  assign done  = busy & ready_in;
  assign abort = busy & ~ready_in & ~g_req;
  assign tmo   = busy & ~ready_in & g_req & expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pk_valid) begin
          state_d = BUSY;
          grant_d = pk_gnt;
          idx_d   = pk_idx;
          last_d  = pk_idx;
        end
      end
      BUSY: begin
        if (done || abort || tmo) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    address_out      = '0;
    read_out         = 1'b0;
    write_out        = 1'b0;
    write_mask_out   = '0;
    write_value_out  = '0;
    m_ready_out      = '0;
    m_fault_out      = '0;
    m_read_value_out = '0;
    if (busy) begin
      address_out = m_address_in[int'(idx_q)*32 +: 32];
      read_out    = m_read_in[idx_q];
      write_out   = m_write_in[idx_q];
      if (m_write_in[idx_q]) begin
        write_mask_out  = m_write_mask_in[int'(idx_q)*4 +: 4];
        write_value_out = m_write_value_in[int'(idx_q)*32 +: 32];
      end
    end
    if (done) begin
      m_ready_out[idx_q] = 1'b1;
      m_fault_out[idx_q] = fault_in;
      m_read_value_out[int'(idx_q)*32 +: 32] = read_value_in;
    end else if (tmo) begin
      m_ready_out[idx_q] = 1'b1;
      m_fault_out[idx_q] = 1'b1;
    end
  end

  assign grant_out = grant_q;

endmodule

// File: doc/mem_bus_rr_arbiter.md
Name: mem_bus_rr_arbiter

Overview:
Round-robin arbiter that shares the single common memory bus (RAM, MMIO peripherals, timer, flash) between NUM_MASTERS requesters: CPU instruction port, CPU data port, and future DMA/sequencer masters. Grants are registered, one transaction per grant. A bus-watchdog timeout converts hung peripherals into faults. It sits between the masters and the address decoder/peripheral OR-mux.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
TIMEOUT, 255, max cycles in BUSY without ready_in before a forced fault (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_address_in  in  NUM_MASTERS x 32  per-master address
m_read_in  in  NUM_MASTERS  per-master read request
m_write_in  in  NUM_MASTERS  per-master write request
m_write_mask_in  in  NUM_MASTERS x 4  per-master byte strobes
m_write_value_in  in  NUM_MASTERS x 32  per-master write data
m_read_value_out  out  NUM_MASTERS x 32  read data, valid with m_ready_out
m_ready_out  out  NUM_MASTERS  one-cycle completion pulse
m_fault_out  out  NUM_MASTERS  one-cycle fault pulse, coincident with m_ready_out
address_out  out  32  bus address
read_out  out  1  bus read
write_out  out  1  bus write
write_mask_out  out  4  bus byte strobes
write_value_out  out  32  bus write data
read_value_in  in  32  bus read data
ready_in  in  1  bus ready (includes decode fault)
fault_in  in  1  bus fault
grant_out  out  NUM_MASTERS  one-hot current grant, for debug/sniffer

Behaviour:
- Request i = m_read_in[i] | m_write_in[i]. A master holds request and all fields stable until its m_ready_out.
- FSM states: IDLE, BUSY. Reset: state=IDLE, grant=0, last=NUM_MASTERS-1, timeout counter=0. All outputs 0 during reset.
- IDLE: if any request, pick first requester searching last+1, last+2, … modulo NUM_MASTERS; register grant and last; go BUSY. Otherwise stay. No bus outputs driven in IDLE (all 0).
- BUSY: bus outputs = granted master's fields (combinational mux). write_mask_out = m_write_in[g] ? m_write_mask_in[g] : 0. write_value_out forced to 0 when no write.
- Completion: ready_in=1 in BUSY → same cycle m_ready_out[g]=1, m_fault_out[g]=fault_in, m_read_value_out[g]=read_value_in; next state IDLE, grant cleared. Non-granted masters see ready/fault/read_value = 0.
- Minimum latency: request seen in cycle N → bus driven N+1 → earliest ready N+1 (combinational slave) → next grant N+2. One idle bubble between transactions is intentional.
- Abort: granted master drops request in BUSY without ready_in → return IDLE, no response pulse, last unchanged.
- ready_in while IDLE is ignored.
- Simultaneous requests at reset release: master 0 wins first (last resets to NUM_MASTERS-1).
- Starvation-free: any persistently requesting master is granted within NUM_MASTERS grants.
- Async reset mid-BUSY: immediate return to IDLE, outputs drop to 0; interrupted master gets no response and must re-issue.

Optional Feature:
MEM_BUS_TIMEOUT_EN.
- Defined: counter increments each BUSY cycle, cleared on entering BUSY. On reaching TIMEOUT without ready_in → m_ready_out[g]=1, m_fault_out[g]=1, m_read_value_out[g]=0, go IDLE. ready_in in the same cycle as expiry takes precedence (normal completion).
- Undefined: no counter; BUSY waits indefinitely for ready_in or abort.

Decomposition:
- Package mem_bus_arb_pkg: state enum (IDLE, BUSY), master index width function/constant, default TIMEOUT constant.
- Sub-module rr_picker: combinational round-robin priority encoder (req vector, last index → one-hot grant + index, valid).

Test Plan:
- Single master 1 reads 0x00010004 with ready_in combinational, read_value_in=0x5 → bus driven cycle after request, m_ready_out[1] pulse with read value 0x5, grant_out=3'b010 during BUSY.
- Masters 0,1,2 request continuously from reset → grant order 0,1,2,0,1,2, each separated by one IDLE cycle.
- Master 2 writes 0x000000AA mask 4'b0001 to 0x00010000 → write_mask_out=4'b0001, write_out=1, write_value_out=0xAA; masks 0 for a read.
- fault_in=1 with ready_in=1 for master 0 address 0x05000000 → m_fault_out[0] and m_ready_out[0] same cycle; others 0.
- MEM_BUS_TIMEOUT_EN, TIMEOUT=4, ready_in held 0 → forced fault pulse on 4th BUSY cycle, then next requester granted; without macro, still BUSY after 100 cycles.
- Assert reset mid-BUSY (cycle 2 of a wait) → outputs 0 immediately, after release master 0 granted first.
